wallace_26x24: RTL and testbench
================================

WALLACE_26X24 -- requirements
Module: wallace_26x24

Interface
REQ-001 Parameter A_W, default 26, width of multiplicand a; the block SHALL support only the default value.
REQ-002 Parameter B_W, default 24, width of multiplier b; the block SHALL support only the default value.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  qualifies a and b in the current cycle.
REQ-006 a  input  26  unsigned multiplicand.
REQ-007 b  input  24  unsigned multiplier.
REQ-008 out_valid  output  1  z holds a valid product this cycle.
REQ-009 z  output  50  unsigned product a*b, full width, no truncation.

Function
REQ-010 z SHALL equal the exact unsigned product a*b, modulo nothing, for every a in 0..2^26-1 and b in 0..2^24-1.
REQ-011 Partial products SHALL be the 24 AND-rows a & {26{b[j]}}, each shifted left by j.
REQ-012 Rows SHALL be reduced to two rows (sum, carry) by a Wallace tree of 3:2 full adders and 2:2 half adders, column-wise, greedy per level.
REQ-013 No operand SHALL be sign-extended; all arithmetic is unsigned.
REQ-014 Pipeline stage 1: the two carry-save rows (50 bits each) and in_valid SHALL be registered at the rising edge following operand presentation.
REQ-015 Pipeline stage 2: a 50-bit carry-propagate addition of the stage-1 rows SHALL be registered into z, with stage-1 valid registered into out_valid.
REQ-016 Latency SHALL be exactly 2 clk rising edges from in_valid=1 with a,b to out_valid=1 with the matching z.
REQ-017 Throughput SHALL be one product per cycle; back-to-back in_valid pulses SHALL yield back-to-back out_valid pulses in order.
REQ-018 No backpressure exists; results SHALL never stall or be dropped.
REQ-019 When in_valid=0, the datapath MAY still compute, but out_valid SHALL be 0 two cycles later; z content then is don't-care yet SHALL still equal the product of the sampled a,b.
REQ-020 Carries out of bit 49 SHALL not occur (max product < 2^50) and SHALL not be required.

Reset
REQ-021 While rst=1, out_valid, z, and both stage-1 rows and stage-1 valid SHALL be 0, asynchronously.
REQ-022 Assertion of rst mid-operation SHALL discard all in-flight products; no out_valid SHALL appear for operands presented before or during reset.
REQ-023 After rst deasserts, the first in_valid sampled SHALL produce out_valid exactly 2 edges later.

Verification
REQ-024 a=0, b=16777215, in_valid=1 -> after 2 edges z=0, out_valid=1.
REQ-025 a=67108863, b=16777215 -> z=1125899822956545 (50-bit all-ones inputs corner).
REQ-026 a=33554432, b=8388608 -> z=281474976710656; a=3, b=5 -> z=15; a=1, b=1 -> z=1.
REQ-027 100 random (a,b) pairs streamed on consecutive cycles with in_valid=1 -> each z equals a*b, in order, out_valid high for 100 consecutive cycles, zero mismatches.
REQ-028 Present a valid operand, assert rst one cycle later for one cycle -> out_valid stays 0 and z=0 throughout; next post-reset operand returns correctly after 2 edges.
REQ-029 in_valid toggling 1,0,1 with distinct operands -> out_valid pattern 1,0,1 delayed by 2 cycles with correct products on valid cycles.

Source files
------------

// File: rtl/wallace_26x24.sv
// 26x24 unsigned multiplier. Stage 1 is a Wallace tree that reduces the partial products to a
// registered sum/carry pair; stage 2 is a registered carry-propagate add. Latency 2, one product per cycle.
module wallace_26x24 #(
  parameter int A_W = 26,
  parameter int B_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_valid,
  output logic [A_W+B_W-1:0] z
);
  localparam int P_W   = A_W + B_W;
  localparam int AI    = $clog2(A_W);
  localparam int BI    = $clog2(B_W);
  localparam int CI    = $clog2(P_W);
  // 24 rows need 7 greedy levels; further levels only pass through once every column is <= 2 high
  localparam int N_LVL = 9;

  logic [P_W-1:0] sum_d, carry_d, sum_q, carry_q;
  logic [P_W-1:0] z_d, z_q;
  logic           vld1_q, vld2_q;

  always_comb begin
    logic [B_W-1:0] cur [P_W];
    logic [B_W-1:0] nxt [P_W];
    int             h   [P_W];
    int             nh  [P_W];
    int             hmax;
    logic           x0, x1, x2;

    hmax = 0;
    x0   = 1'b0;
    x1   = 1'b0;
    x2   = 1'b0;
    for (int c = 0; c < P_W; c++) begin
      cur[CI'(c)] = '0;
      nxt[CI'(c)] = '0;
      h[CI'(c)]   = 0;
      nh[CI'(c)]  = 0;
    end

    // Partial product j is a & {A_W{b[j]}} shifted left by j; stack each bit into its column.
    for (int j = 0; j < B_W; j++) begin
      for (int i = 0; i < A_W; i++) begin
        cur[CI'(i + j)][BI'(h[CI'(i + j)])] = a[AI'(i)] & b[BI'(j)];
        h[CI'(i + j)] = h[CI'(i + j)] + 1;
      end
    end

    for (int lvl = 0; lvl < N_LVL; lvl++) begin
      hmax = 0;
      for (int c = 0; c < P_W; c++) begin
        if (h[CI'(c)] > hmax) hmax = h[CI'(c)];
        nxt[CI'(c)] = '0;
        nh[CI'(c)]  = 0;
      end

      for (int c = 0; c < P_W; c++) begin
        if (hmax <= 2) begin
          nxt[CI'(c)] = cur[CI'(c)];
          nh[CI'(c)]  = h[CI'(c)];
        end else begin
          for (int k = 0; k < B_W / 3; k++) begin
            if (3 * k + 2 < h[CI'(c)]) begin
              x0 = cur[CI'(c)][BI'(3 * k)];
              x1 = cur[CI'(c)][BI'(3 * k + 1)];
              x2 = cur[CI'(c)][BI'(3 * k + 2)];
              nxt[CI'(c)][BI'(nh[CI'(c)])] = x0 ^ x1 ^ x2;
              nh[CI'(c)] = nh[CI'(c)] + 1;
              // Carries beyond the top column cannot occur for a full-range product.
              if (c + 1 < P_W) begin
                nxt[CI'(c + 1)][BI'(nh[CI'(c + 1)])] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                nh[CI'(c + 1)] = nh[CI'(c + 1)] + 1;
              end
            end
          end
          if (h[CI'(c)] % 3 == 2) begin
            x0 = cur[CI'(c)][BI'(h[CI'(c)] - 2)];
            x1 = cur[CI'(c)][BI'(h[CI'(c)] - 1)];
            nxt[CI'(c)][BI'(nh[CI'(c)])] = x0 ^ x1;
            nh[CI'(c)] = nh[CI'(c)] + 1;
            if (c + 1 < P_W) begin
              nxt[CI'(c + 1)][BI'(nh[CI'(c + 1)])] = x0 & x1;
              nh[CI'(c + 1)] = nh[CI'(c + 1)] + 1;
            end
          end else if (h[CI'(c)] % 3 == 1) begin
            nxt[CI'(c)][BI'(nh[CI'(c)])] = cur[CI'(c)][BI'(h[CI'(c)] - 1)];
            nh[CI'(c)] = nh[CI'(c)] + 1;
          end
        end
      end

      cur = nxt;
      h   = nh;
    end

    sum_d   = '0;
    carry_d = '0;
    for (int c = 0; c < P_W; c++) begin
      sum_d[CI'(c)]   = cur[CI'(c)][0];
      carry_d[CI'(c)] = cur[CI'(c)][1];
    end
  end

  assign z_d = sum_q + carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      vld1_q  <= 1'b0;
      z_q     <= '0;
      vld2_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld1_q  <= in_valid;
      z_q     <= z_d;
      vld2_q  <= vld1_q;
    end
  end

  assign z         = z_q;
  assign out_valid = vld2_q;

endmodule

// File: tb/tb_wallace_26x24.sv
// Self-checking bench for wallace_26x24: corner operands, a random back-to-back stream,
// mid-operation reset and sparse valid patterns against a plain-arithmetic product model.
module tb_wallace_26x24;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [25:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic [49:0] z;

  int vectors     = 0;
  int miscompares = 0;

  wallace_26x24 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .z        (z)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] prod(input logic [25:0] x, input logic [23:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    return p[49:0];
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 26'($urandom());
    b        = 24'($urandom());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || z !== 50'd0) begin
        miscompares++;
        $display("FAIL reset_hold%0d: out_valid=%0b z=%0d, required out_valid=0 z=0", i, out_valid, z);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle%0d: out_valid=%0b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_corners();
    logic [25:0] ta [6];
    logic [23:0] tb_ [6];
    logic [49:0] ez [6];
    ta  = '{26'd0, 26'd67108863, 26'd33554432, 26'd3, 26'd1, 26'd67108863};
    tb_ = '{24'd16777215, 24'd16777215, 24'd8388608, 24'd5, 24'd1, 24'd1};
    ez  = '{50'd0, 50'd1125899822956545, 50'd281474976710656, 50'd15, 50'd1, 50'd67108863};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++;
        if (out_valid !== 1'b1 || z !== ez[i-2]) begin
          miscompares++;
          $display("FAIL corner%0d: out_valid=%0b z=%0d, required out_valid=1 z=%0d",
                   i - 2, out_valid, z, ez[i-2]);
        end
      end
      if (i < 6) begin
        in_valid = 1'b1;
        a        = ta[i];
        b        = tb_[i];
      end else begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] ea [100];
    logic [23:0] eb [100];
    int run;
    run = 0;
    for (int i = 0; i < 100; i++) begin
      ea[i] = 26'($urandom());
      eb[i] = 24'($urandom());
      if (i % 17 == 5) ea[i] = '1;
      if (i % 13 == 7) eb[i] = '1;
    end
    for (int i = 0; i < 103; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 102) begin
        vectors++;
        if (out_valid === 1'b1) run++;
        if (out_valid !== 1'b1 || z !== prod(ea[i-2], eb[i-2])) begin
          miscompares++;
          $display("FAIL stream%0d: out_valid=%0b z=%0d, required out_valid=1 z=%0d",
                   i - 2, out_valid, z, prod(ea[i-2], eb[i-2]));
        end
      end
      if (i < 100) begin
        in_valid = 1'b1;
        a        = ea[i];
        b        = eb[i];
      end else begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
      end
    end
    vectors++;
    if (run != 100) begin
      miscompares++;
      $display("FAIL stream_run: consecutive valid=%0d, required 100", run);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_tail: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] ax, a1, a3;
    logic [23:0] bx, b1, b3;
    ax = 26'($urandom()) | 26'd1;
    bx = 24'($urandom()) | 24'd1;
    a1 = 26'($urandom()) | 26'd1;
    b1 = 24'($urandom()) | 24'd1;
    a3 = 26'($urandom());
    b3 = 24'($urandom());

    @(negedge clk);
    in_valid = 1'b0; a = ax; b = bx;
    @(negedge clk);
    in_valid = 1'b1; a = a1; b = b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || z !== prod(ax, bx)) begin
      miscompares++;
      $display("FAIL rstmid_pre: out_valid=%0b z=%0d, required out_valid=0 z=%0d",
               out_valid, z, prod(ax, bx));
    end
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || z !== 50'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: out_valid=%0b z=%0d, required out_valid=0 z=0", out_valid, z);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || z !== 50'd0) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: out_valid=%0b z=%0d, required out_valid=0 z=0", i, out_valid, z);
      end
      @(negedge clk);
    end
    in_valid = 1'b1; a = a3; b = b3;
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_early: out_valid=%0b after 1 edge, required 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || z !== prod(a3, b3)) begin
      miscompares++;
      $display("FAIL rstmid_first: out_valid=%0b z=%0d, required out_valid=1 z=%0d",
               out_valid, z, prod(a3, b3));
    end
    @(negedge clk);
  endtask

  task automatic test_toggle();
    logic        pv [6];
    logic [25:0] pa [6];
    logic [23:0] pb [6];
    pv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      pa[i] = 26'($urandom());
      pb[i] = 24'($urandom());
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++;
        if (out_valid !== pv[i-2] || z !== prod(pa[i-2], pb[i-2])) begin
          miscompares++;
          $display("FAIL toggle%0d: out_valid=%0b z=%0d, required out_valid=%0b z=%0d",
                   i - 2, out_valid, z, pv[i-2], prod(pa[i-2], pb[i-2]));
        end
      end
      if (i < 6) begin
        in_valid = pv[i];
        a        = pa[i];
        b        = pb[i];
      end else begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
